// File: rtl/i_arb4_wrr.sv
// i_arb4_wrr: packet-granular weighted round-robin arbiter for a 4:1 merge.
// A grant is held from the header beat to the last beat of a packet, and a
// port may keep the grant for up to weight[p] consecutive packets per turn.
// Optional stall watchdog: define I_ARB4_WRR_WDOG_EN to build it; otherwise
// o_wdog_err is tied low.
module i_arb4_wrr #(
    parameter int W_BITS         = 4,
    parameter int DEFAULT_WEIGHT = 1,
    parameter int WDOG_CYCLES    = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        i_req,
    input  logic              i_beat_fire,
    input  logic              i_beat_last,
    output logic [3:0]        o_grant,
    output logic [1:0]        o_grant_id,
    output logic              o_grant_valid,
    input  logic              i_cfg_we,
    input  logic [1:0]        i_cfg_port,
    input  logic [W_BITS-1:0] i_cfg_weight,
    output logic              o_wdog_err
);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t            r_state;
    logic [3:0]        r_grant;
    logic [1:0]        r_grant_id;
    logic [1:0]        r_rr_ptr;
    logic [W_BITS-1:0] r_credit;
    logic [W_BITS-1:0] r_weight [4];

    logic [3:0]        w_elig;
    logic              w_pick_vld;
    logic [1:0]        w_pick_id;
    logic [1:0]        w_idx;
    logic [W_BITS-1:0] w_credit_next;

    // Ports with a zero weight are masked out of arbitration entirely.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < 4; i++) begin
            w_elig[i] = i_req[i] & (r_weight[i] != '0);
        end
    end

    // First eligible port searching from r_rr_ptr upward; walking the offsets
    // from farthest to nearest lets the nearest hit overwrite the others.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_id  = r_rr_ptr;
        w_idx      = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_rr_ptr + 2'(k);
            if (w_elig[w_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_id  = w_idx;
            end
        end
    end

    assign w_credit_next = r_credit - 1'b1;

    // Weight table; a write only matters at the next credit load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) r_weight[i] <= W_BITS'(DEFAULT_WEIGHT);
        end else if (i_cfg_we) begin
            r_weight[i_cfg_port] <= i_cfg_weight;
        end
    end

    // Arbitration FSM: grant, id, credit and round-robin pointer are all
    // registered here, so the grant cannot glitch mid-packet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_credit   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant    <= 4'b0001 << w_pick_id;
                        r_grant_id <= w_pick_id;
                        r_credit   <= r_weight[w_pick_id];
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (i_beat_fire && i_beat_last) begin
                        if ((w_credit_next != '0) && i_req[r_grant_id]) begin
                            r_credit <= w_credit_next;
                        end else begin
                            r_grant  <= '0;
                            r_rr_ptr <= r_grant_id + 2'd1;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_id    = r_grant_id;
    assign o_grant_valid = |r_grant;

`ifdef I_ARB4_WRR_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wdog_err;

    // Count consecutive stalled GRANT cycles; flag sticks until reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd_cnt   <= '0;
            r_wdog_err <= 1'b0;
        end else if (r_state == ST_GRANT && !i_beat_fire) begin
            if (r_wd_cnt != WD_W'(WDOG_CYCLES)) r_wd_cnt <= r_wd_cnt + 1'b1;
            if (r_wd_cnt == WD_W'(WDOG_CYCLES - 1)) r_wdog_err <= 1'b1;
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign o_wdog_err = r_wdog_err;
`else
    assign o_wdog_err = 1'b0;
`endif

endmodule
